// File: rtl/module_lpf_biquad_pkg.sv
// Shared constants and types for the direct-form-I low-pass biquad stage.
// Holds the DSP opmode encodings, Q2.16 constants and the flat DSP bus layout.
`timescale 1ns/1ps
package module_lpf_biquad_pkg;

  // DSP opmode encodings
  localparam logic [7:0] DSP_NONE = 8'h00;

  // Q2.16 constants
  localparam logic [17:0] Q_ONE     = 18'h10000;
  localparam logic [17:0] Q_SAT_MAX = 18'h1FFFF;
  localparam logic [17:0] Q_SAT_MIN = 18'h20000;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDrain
  } state_e;

  typedef struct packed {
    logic [7:0]  opmode;
    logic [17:0] a;
    logic [17:0] b;
    logic [47:0] c;
  } dsp_ins_t;

endpackage

// File: rtl/module_lpf_biquad.sv
// Direct-form-I biquad IIR low-pass stage time-multiplexed onto a shared DSP slice.
// Each sample issues five taps, one per cycle, then drains the DSP pipeline.
`timescale 1ns/1ps
module module_lpf_biquad
  import module_lpf_biquad_pkg::*;
#(
  parameter int unsigned DSP_LAT = 2,
  parameter int unsigned ACC_W   = 40
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [89:0] coefs_flat,
  input  logic        coefs_valid,
  input  logic [17:0] sample_in,
  input  logic        sample_in_valid,
  output logic        sample_in_ready,
  input  logic        hist_clr,
  output logic [17:0] sample_out,
  output logic        sample_out_valid,
  input  logic [83:0] dsp_outs_flat,
  output logic [91:0] dsp_ins_flat
);

  localparam logic signed [ACC_W-1:0] SatHi = {{(ACC_W-18){1'b0}}, Q_SAT_MAX};
  localparam logic signed [ACC_W-1:0] SatLo = {{(ACC_W-18){1'b1}}, Q_SAT_MIN};

  function automatic logic [17:0] sat18(input logic signed [ACC_W-1:0] v);
    if (v > SatHi) begin
      return Q_SAT_MAX;
    end else if (v < SatLo) begin
      return Q_SAT_MIN;
    end
    return v[17:0];
  endfunction

  state_e              state_q;
  logic [2:0]          tap_q;
  logic [89:0]         coefs_act_q;
  logic [89:0]         coefs_shd_q;
  logic                pending_q;
  logic [17:0]         x_q;
  logic [17:0]         x1_q;
  logic [17:0]         x2_q;
  logic [17:0]         y1_q;
  logic [17:0]         y2_q;
  logic signed [ACC_W-1:0] acc_q;
  logic [DSP_LAT-1:0]  pipe_vld_q;
  logic [DSP_LAT-1:0]  pipe_last_q;
  logic [17:0]         sample_out_q;
  logic                sample_out_valid_q;

  logic                issuing;
  logic                tap_last;
  logic [17:0]         tap_coef;
  logic [17:0]         tap_opnd;
  logic [35:0]         m;
  logic signed [ACC_W-1:0] m_ext;
  logic signed [ACC_W-1:0] acc_next;
  logic signed [ACC_W-1:0] acc_shr;
  logic [17:0]         y_sat;
  logic                m_take;
  logic                done;
  dsp_ins_t            dsp_ins;
  logic                unused_p;

  assign issuing  = (state_q == StIssue);
  assign tap_last = (tap_q == 3'd4);

  always_comb begin
    tap_coef = '0;
    tap_opnd = '0;
    unique case (tap_q)
      3'd0: begin tap_coef = coefs_act_q[53:36]; tap_opnd = x_q;  end
      3'd1: begin tap_coef = coefs_act_q[35:18]; tap_opnd = x1_q; end
      3'd2: begin tap_coef = coefs_act_q[17:0];  tap_opnd = x2_q; end
      3'd3: begin tap_coef = coefs_act_q[89:72]; tap_opnd = y1_q; end
      3'd4: begin tap_coef = coefs_act_q[71:54]; tap_opnd = y2_q; end
      default: ;
    endcase
  end

  always_comb begin
    dsp_ins = '0;
    if (issuing) begin
      dsp_ins.opmode = DSP_NONE;
      dsp_ins.a      = tap_coef;
      dsp_ins.b      = tap_opnd;
      dsp_ins.c      = '0;
    end
  end

  assign dsp_ins_flat = dsp_ins;

  // The c1 tap is always issued last, so the "last" flag doubles as "subtract".
  assign m        = dsp_outs_flat[83:48];
  assign m_ext    = {{(ACC_W-36){m[35]}}, m};
  assign m_take   = pipe_vld_q[DSP_LAT-1];
  assign done     = m_take && pipe_last_q[DSP_LAT-1];
  assign acc_next = pipe_last_q[DSP_LAT-1] ? (acc_q - m_ext) : (acc_q + m_ext);
  assign acc_shr  = acc_next >>> 16;
  assign y_sat    = sat18(acc_shr);
  assign unused_p = ^dsp_outs_flat[47:0];

  assign sample_in_ready  = (state_q == StIdle);
  assign sample_out       = sample_out_q;
  assign sample_out_valid = sample_out_valid_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q            <= StIdle;
      tap_q              <= '0;
      coefs_act_q        <= '0;
      coefs_shd_q        <= '0;
      pending_q          <= 1'b0;
      x_q                <= '0;
      x1_q               <= '0;
      x2_q               <= '0;
      y1_q               <= '0;
      y2_q               <= '0;
      acc_q              <= '0;
      pipe_vld_q         <= '0;
      pipe_last_q        <= '0;
      sample_out_q       <= '0;
      sample_out_valid_q <= 1'b0;
    end else begin
      sample_out_valid_q <= 1'b0;
      pipe_vld_q         <= DSP_LAT'({pipe_vld_q, issuing});
      pipe_last_q        <= DSP_LAT'({pipe_last_q, issuing && tap_last});

      // Swap coefficients only between samples; a fresh load wins over the swap.
      if (state_q == StIdle && pending_q) begin
        coefs_act_q <= coefs_shd_q;
        pending_q   <= 1'b0;
      end
      if (coefs_valid) begin
        coefs_shd_q <= coefs_flat;
        pending_q   <= 1'b1;
      end

      if (m_take) begin
        acc_q <= acc_next;
      end

      unique case (state_q)
        StIdle: begin
          if (sample_in_valid) begin
            x_q     <= sample_in;
            acc_q   <= '0;
            tap_q   <= '0;
            state_q <= StIssue;
          end
        end
        StIssue: begin
          if (tap_last) begin
            state_q <= StDrain;
          end else begin
            tap_q <= tap_q + 3'd1;
          end
        end
        StDrain: begin
          if (done) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase

      if (done) begin
        sample_out_q       <= y_sat;
        sample_out_valid_q <= 1'b1;
        x2_q               <= x1_q;
        x1_q               <= x_q;
        y2_q               <= y1_q;
        y1_q               <= y_sat;
      end

      if (hist_clr) begin
        x1_q <= '0;
        x2_q <= '0;
        y1_q <= '0;
        y2_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_module_lpf_biquad.sv
// Directed bench for module_lpf_biquad with a two-stage multiplier model on the DSP bus.
// Expected outputs are hand-computed Q2.16 values.
`timescale 1ns/1ps
module tb_module_lpf_biquad;
  import module_lpf_biquad_pkg::*;

  localparam logic [17:0] Z    = 18'h00000;
  localparam logic [17:0] HALF = 18'h08000;

  logic        clk = 1'b0;
  logic        reset;
  logic [89:0] coefs_flat;
  logic        coefs_valid;
  logic [17:0] sample_in;
  logic        sample_in_valid;
  logic        sample_in_ready;
  logic        hist_clr;
  logic [17:0] sample_out;
  logic        sample_out_valid;
  logic [83:0] dsp_outs_flat;
  logic [91:0] dsp_ins_flat;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  module_lpf_biquad #(
    .DSP_LAT(2),
    .ACC_W  (40)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .coefs_flat      (coefs_flat),
    .coefs_valid     (coefs_valid),
    .sample_in       (sample_in),
    .sample_in_valid (sample_in_valid),
    .sample_in_ready (sample_in_ready),
    .hist_clr        (hist_clr),
    .sample_out      (sample_out),
    .sample_out_valid(sample_out_valid),
    .dsp_outs_flat   (dsp_outs_flat),
    .dsp_ins_flat    (dsp_ins_flat)
  );

  // Shared DSP slice model: m = a*b, valid two cycles after the inputs.
  logic signed [35:0] prod_s1 = '0;
  logic signed [35:0] prod_s2 = '0;
  always @(posedge clk) begin
    prod_s1 <= $signed(dsp_ins_flat[83:66]) * $signed(dsp_ins_flat[65:48]);
    prod_s2 <= prod_s1;
  end
  assign dsp_outs_flat = {prod_s2, 48'h0};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [91:0] obs, input logic [91:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [89:0] mk(input logic [17:0] c0, input logic [17:0] c1,
                                     input logic [17:0] c2, input logic [17:0] c3,
                                     input logic [17:0] c4);
    return {c0, c1, c2, c3, c4};
  endfunction

  function automatic logic [91:0] dsp_exp(input int ph, input logic [89:0] c,
                                          input logic [17:0] xx, input logic [17:0] x1,
                                          input logic [17:0] x2, input logic [17:0] y1,
                                          input logic [17:0] y2);
    case (ph)
      1: return {DSP_NONE, c[53:36], xx, 48'h0};
      2: return {DSP_NONE, c[35:18], x1, 48'h0};
      3: return {DSP_NONE, c[17:0],  x2, 48'h0};
      4: return {DSP_NONE, c[89:72], y1, 48'h0};
      5: return {DSP_NONE, c[71:54], y2, 48'h0};
      default: return 92'h0;
    endcase
  endfunction

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!sample_in_ready && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_rdy"}, 92'(sample_in_ready), 92'(1));
  endtask

  task automatic load_coefs(input logic [89:0] c);
    coefs_flat  = c;
    coefs_valid = 1'b1;
    step();
    coefs_valid = 1'b0;
    step();
  endtask

  task automatic hist_clear();
    hist_clr = 1'b1;
    step();
    hist_clr = 1'b0;
  endtask

  // load_at: -1 no load, 0 load in the accept cycle, k load in cycle N+k.
  task automatic run_sample(input string tag, input logic [17:0] x, input logic [17:0] y_exp,
                            input int load_at, input logic [89:0] new_coefs);
    wait_ready(tag);
    sample_in       = x;
    sample_in_valid = 1'b1;
    if (load_at == 0) begin
      coefs_flat  = new_coefs;
      coefs_valid = 1'b1;
    end
    for (int i = 1; i <= 8; i++) begin
      step();
      sample_in_valid = 1'b0;
      coefs_valid     = 1'b0;
      if (i == load_at) begin
        coefs_flat  = new_coefs;
        coefs_valid = 1'b1;
      end
      if (i == 1) chk({tag, "_busy"}, 92'(sample_in_ready), 92'(0));
      if (i == 7) chk({tag, "_early"}, 92'(sample_out_valid), 92'(0));
    end
    chk({tag, "_vld"}, 92'(sample_out_valid), 92'(1));
    chk({tag, "_y"}, 92'(sample_out), 92'(y_exp));
    step();
    chk({tag, "_vld_off"}, 92'(sample_out_valid), 92'(0));
    chk({tag, "_hold"}, 92'(sample_out), 92'(y_exp));
  endtask

  initial begin
    logic [89:0] cur;
    logic [17:0] mx1, mx2, my1, my2;
    logic        seen;
    int          ph;

    reset           = 1'b1;
    coefs_flat      = '0;
    coefs_valid     = 1'b0;
    sample_in       = '0;
    sample_in_valid = 1'b0;
    hist_clr        = 1'b0;
    step();
    step();
    chk("reset_y", 92'(sample_out), 92'(0));
    chk("reset_vld", 92'(sample_out_valid), 92'(0));
    chk("reset_rdy", 92'(sample_in_ready), 92'(1));
    chk("reset_dsp", dsp_ins_flat, 92'h0);
    reset = 1'b0;
    step();

    // Pass-through, then probe x1 and x2 history via c3 and c4.
    load_coefs(mk(Z, Z, Q_ONE, Z, Z));
    run_sample("pass", HALF, HALF, -1, '0);
    load_coefs(mk(Z, Z, Z, Q_ONE, Z));
    run_sample("x1", Z, HALF, -1, '0);
    load_coefs(mk(Z, Z, Z, Z, Q_ONE));
    run_sample("x2", Z, HALF, -1, '0);

    // y = 0.5x + y1: impulse response holds at 0.5.
    hist_clear();
    load_coefs(mk(Q_ONE, Z, HALF, Z, Z));
    run_sample("imp0", Q_ONE, HALF, -1, '0);
    run_sample("imp1", Z, HALF, -1, '0);
    run_sample("imp2", Z, HALF, -1, '0);

    // y = x + x1 + x2 with saturation in both directions.
    hist_clear();
    load_coefs(mk(Z, Z, Q_ONE, Q_ONE, Q_ONE));
    run_sample("satp0", 18'h1C000, 18'h1C000, -1, '0);
    run_sample("satp1", 18'h1C000, 18'h1FFFF, -1, '0);
    run_sample("satp2", 18'h1C000, 18'h1FFFF, -1, '0);
    hist_clear();
    run_sample("satn0", 18'h24000, 18'h24000, -1, '0);
    run_sample("satn1", 18'h24000, 18'h20000, -1, '0);
    run_sample("satn2", 18'h24000, 18'h20000, -1, '0);

    // Load mid-computation: current sample keeps x+x1+x2, next uses 0.5x.
    hist_clear();
    run_sample("mid_old", 18'h04000, 18'h04000, 3, mk(Z, Z, HALF, Z, Z));
    run_sample("mid_new", 18'h04000, 18'h02000, -1, '0);

    // Load in the accept cycle: that sample still uses 0.5x.
    hist_clear();
    run_sample("same_old", 18'h04000, 18'h02000, 0, mk(Z, Z, Q_ONE, Z, Z));
    run_sample("same_new", 18'h04000, 18'h04000, -1, '0);

    // y = x - y2 exercises the subtracted tap.
    hist_clear();
    load_coefs(mk(Z, Q_ONE, Q_ONE, Z, Z));
    run_sample("sub0", 18'h04000, 18'h04000, -1, '0);
    run_sample("sub1", Z, Z, -1, '0);
    run_sample("sub2", Z, 18'h3C000, -1, '0);

    // Valid held high: accepts every 8 cycles, bus idle outside ISSUE.
    hist_clear();
    cur = mk(Z, Z, Q_ONE, Z, Z);
    load_coefs(cur);
    mx1 = Z; mx2 = Z; my1 = Z; my2 = Z;
    sample_in       = 18'h01000;
    sample_in_valid = 1'b1;
    for (int i = 1; i <= 24; i++) begin
      step();
      if (i == 17) sample_in_valid = 1'b0;
      ph = i % 8;
      chk("cont_rdy", 92'(sample_in_ready), 92'(ph == 0));
      chk("cont_dsp", dsp_ins_flat, dsp_exp(ph, cur, 18'h01000, mx1, mx2, my1, my2));
      chk("cont_vld", 92'(sample_out_valid), 92'(ph == 0));
      if (ph == 0) begin
        chk("cont_y", 92'(sample_out), 92'(18'h01000));
        mx2 = mx1; mx1 = 18'h01000;
        my2 = my1; my1 = 18'h01000;
      end
    end

    // Reset in the middle of a computation.
    step();
    sample_in       = 18'h03000;
    sample_in_valid = 1'b1;
    step();
    sample_in_valid = 1'b0;
    step();
    step();
    step();
    reset = 1'b1;
    #1;
    chk("rst_y", 92'(sample_out), 92'(0));
    chk("rst_vld", 92'(sample_out_valid), 92'(0));
    chk("rst_rdy", 92'(sample_in_ready), 92'(1));
    chk("rst_dsp", dsp_ins_flat, 92'h0);
    step();
    reset = 1'b0;
    seen  = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (sample_out_valid) seen = 1'b1;
    end
    chk("rst_no_out", 92'(seen), 92'(0));
    load_coefs(mk(Q_ONE, Q_ONE, HALF, Q_ONE, Q_ONE));
    run_sample("rst_first", 18'h03000, 18'h01800, -1, '0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
